// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner and the calculator FSMs that consume its key codes.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_D   = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_ENT = 4'd15;

  // Physical (row,col) position to the code seen by the calculator.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'd0:  code = 4'd1;
      4'd1:  code = 4'd2;
      4'd2:  code = 4'd3;
      4'd3:  code = KEY_ADD;
      4'd4:  code = 4'd4;
      4'd5:  code = 4'd5;
      4'd6:  code = 4'd6;
      4'd7:  code = KEY_SUB;
      4'd8:  code = 4'd7;
      4'd9:  code = 4'd8;
      4'd10: code = 4'd9;
      4'd11: code = KEY_MUL;
      4'd12: code = KEY_CLR;
      4'd13: code = 4'd0;
      4'd14: code = KEY_ENT;
      4'd15: code = KEY_D;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles at all-released.
module sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce; one key_valid strobe per physical press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW      = $clog2(MAX_CNT);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);

  state_t        state;
  logic [3:0]    row_s;
  logic          row_any;
  logic [1:0]    row_idx;
  logic [1:0]    row_lat;
  logic [1:0]    col_idx;
  logic [CW-1:0] dwell;
  logic [CW-1:0] deb;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_s)
  );

  // Several rows low at once resolve to the lowest row index.
  always_comb begin
    row_any = ~&row_s;
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_s[r]) row_idx = 2'(r);
    end
  end

  // col_n is rotated as a register so it never passes through a non-one-cold value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_n     <= 4'b1110;
      col_idx   <= 2'd0;
      row_lat   <= 2'd0;
      dwell     <= '0;
      deb       <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (row_any) begin
              row_lat <= row_idx;
              deb     <= '0;
              state   <= DEBOUNCE;
            end else begin
              col_n   <= {col_n[2:0], col_n[3]};
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            dwell <= dwell + CW'(1);
          end
        end
        DEBOUNCE: begin
          if (row_any && (row_idx == row_lat)) begin
            if (deb == DEB_LAST) begin
              key_code  <= key_map(row_lat, col_idx);
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= PRESSED;
            end else begin
              deb <= deb + CW'(1);
            end
          end else begin
            col_n   <= {col_n[2:0], col_n[3]};
            col_idx <= col_idx + 2'd1;
            dwell   <= '0;
            state   <= SCAN;
          end
        end
        PRESSED: begin
          if (!row_any) begin
            deb   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (row_any) begin
            state <= PRESSED;
          end else if (deb == DEB_LAST) begin
            key_held <= 1'b0;
            col_n    <= {col_n[2:0], col_n[3]};
            col_idx  <= col_idx + 2'd1;
            dwell    <= '0;
            state    <= SCAN;
          end else begin
            deb <= deb + CW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural key matrix drives row_n from col_n.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys = '0;
  int          checks = 0;
  int          errors = 0;
  int          ev_count = 0;
  logic [3:0]  last_code = 4'd0;
  int          double_valid = 0;
  int          col_bad = 0;
  logic        prev_valid = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // A pressed key at (r,c) pulls row r low whenever column c is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (key_valid) begin
        ev_count++;
        last_code = key_code;
        if (prev_valid) double_valid++;
      end
      prev_valid = key_valid;
      if ($countones(~col_n) != 1) col_bad++;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] seq [4];
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
    keys  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (col_n !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col: got %b expected 1110", col_n); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("[TB] FAIL reset_code: got %0d expected 0", key_code); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL reset_held: got %b expected 0", key_held); end
    cycles(3);
    checks++; if (col_n !== 4'b1110) begin errors++; $display("[TB] FAIL dwell_end_col: got %b expected 1110", col_n); end
    cycles(1);
    checks++; if (col_n !== seq[0]) begin errors++; $display("[TB] FAIL col_step0: got %b expected %b", col_n, seq[0]); end
    for (int i = 1; i < 4; i++) begin
      cycles(4);
      checks++; if (col_n !== seq[i]) begin errors++; $display("[TB] FAIL col_step%0d: got %b expected %b", i, col_n, seq[i]); end
    end
  endtask

  task automatic test_clean_press();
    int ev0;
    ev0 = ev_count;
    keys[3] = 1'b1;
    cycles(40);
    checks++; if (ev_count - ev0 != 1) begin errors++; $display("[TB] FAIL clean_events: got %0d expected 1", ev_count - ev0); end
    checks++; if (last_code !== 4'd10) begin errors++; $display("[TB] FAIL clean_code: got %0d expected 10", last_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL clean_held: got %b expected 1", key_held); end
    keys = '0;
    cycles(9);
    checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL clean_held_release9: got %b expected 1", key_held); end
    cycles(5);
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL clean_held_release14: got %b expected 0", key_held); end
    checks++; if (col_n !== 4'b1110) begin errors++; $display("[TB] FAIL clean_resume_col: got %b expected 1110", col_n); end
    checks++; if (key_code !== 4'd10) begin errors++; $display("[TB] FAIL clean_code_hold: got %0d expected 10", key_code); end
    checks++; if (ev_count - ev0 != 1) begin errors++; $display("[TB] FAIL clean_events_after: got %0d expected 1", ev_count - ev0); end
  endtask

  task automatic test_bouncy_press();
    int ev0;
    ev0 = ev_count;
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) keys[9] = ~keys[9];
      cycles(1);
    end
    checks++; if (ev_count != ev0) begin errors++; $display("[TB] FAIL bounce_no_event: got %0d expected 0", ev_count - ev0); end
    cycles(40);
    checks++; if (ev_count - ev0 != 1) begin errors++; $display("[TB] FAIL bounce_events: got %0d expected 1", ev_count - ev0); end
    checks++; if (last_code !== 4'd8) begin errors++; $display("[TB] FAIL bounce_code: got %0d expected 8", last_code); end
    keys = '0;
    cycles(20);
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL bounce_released: got %b expected 0", key_held); end
  endtask

  task automatic test_release_bounce();
    int ev0;
    ev0 = ev_count;
    keys[14] = 1'b1;
    cycles(40);
    checks++; if (ev_count - ev0 != 1) begin errors++; $display("[TB] FAIL relb_events: got %0d expected 1", ev_count - ev0); end
    checks++; if (last_code !== 4'd15) begin errors++; $display("[TB] FAIL relb_code: got %0d expected 15", last_code); end
    keys = '0;
    cycles(4);
    keys[14] = 1'b1;
    cycles(2);
    checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL relb_held_bounce: got %b expected 1", key_held); end
    keys = '0;
    cycles(9);
    checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL relb_held9: got %b expected 1", key_held); end
    cycles(5);
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL relb_held14: got %b expected 0", key_held); end
    checks++; if (ev_count - ev0 != 1) begin errors++; $display("[TB] FAIL relb_no_second: got %0d expected 1", ev_count - ev0); end
  endtask

  task automatic test_back_to_back();
    int ev0;
    ev0 = ev_count;
    keys[4] = 1'b1;
    cycles(40);
    checks++; if (ev_count - ev0 != 1) begin errors++; $display("[TB] FAIL b2b_first_events: got %0d expected 1", ev_count - ev0); end
    checks++; if (last_code !== 4'd4) begin errors++; $display("[TB] FAIL b2b_first_code: got %0d expected 4", last_code); end
    keys[7] = 1'b1;
    cycles(10);
    checks++; if (ev_count - ev0 != 1) begin errors++; $display("[TB] FAIL b2b_second_blocked: got %0d expected 1", ev_count - ev0); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL b2b_held: got %b expected 1", key_held); end
    keys[4] = 1'b0;
    cycles(50);
    checks++; if (ev_count - ev0 != 2) begin errors++; $display("[TB] FAIL b2b_events: got %0d expected 2", ev_count - ev0); end
    checks++; if (last_code !== 4'd11) begin errors++; $display("[TB] FAIL b2b_second_code: got %0d expected 11", last_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_held: got %b expected 1", key_held); end
    keys = '0;
    cycles(20);
  endtask

  task automatic test_reset_mid_debounce();
    int ev0;
    keys  = '0;
    rst_n = 1'b0;
    cycles(2);
    keys[0] = 1'b1;
    rst_n   = 1'b1;
    ev0     = ev_count;
    cycles(8);
    checks++; if (ev_count != ev0) begin errors++; $display("[TB] FAIL mid_no_event: got %0d expected 0", ev_count - ev0); end
    rst_n = 1'b0;
    #1;
    checks++; if (col_n !== 4'b1110) begin errors++; $display("[TB] FAIL mid_reset_col: got %b expected 1110", col_n); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset_code: got %0d expected 0", key_code); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_held: got %b expected 0", key_held); end
    repeat (2) @(negedge clk);
    checks++; if (ev_count != ev0) begin errors++; $display("[TB] FAIL mid_no_event_reset: got %0d expected 0", ev_count - ev0); end
    rst_n = 1'b1;
    cycles(SCAN_DIV + 2 + DEBOUNCE_CNT + 1);
    checks++; if (ev_count - ev0 != 1) begin errors++; $display("[TB] FAIL mid_rediscover: got %0d expected 1", ev_count - ev0); end
    checks++; if (last_code !== 4'd1) begin errors++; $display("[TB] FAIL mid_code: got %0d expected 1", last_code); end
    keys = '0;
    cycles(20);
  endtask

  task automatic test_invariants();
    checks++; if (double_valid != 0) begin errors++; $display("[TB] FAIL valid_twice: got %0d expected 0", double_valid); end
    checks++; if (col_bad != 0) begin errors++; $display("[TB] FAIL col_one_cold: got %0d expected 0", col_bad); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_release_bounce();
    test_back_to_back();
    test_reset_mid_debounce();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
